// File: rtl/fft_stream_ctrl_pkg.sv
// Shared definitions for the fft stream controller: default sizing and FSM states.
package fft_stream_ctrl_pkg;

    localparam int unsigned LOGN_DEF       = 12;
    localparam int unsigned DW_DEF         = 128;
    localparam int unsigned READ_LAT_DEF   = 2;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned GUARD_DEF      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count; used as the output skid buffer.
module stream_fifo #(
    parameter int unsigned DW    = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fft_stream_ctrl.sv
// Load/start/unload sequencer around the fft core: bit-reversed RAM load, start strobe,
// completion wait, then natural-order readout through a skid FIFO.
module fft_stream_ctrl
    import fft_stream_ctrl_pkg::*;
#(
    parameter int unsigned LOGN       = LOGN_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned READ_LAT   = READ_LAT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned GUARD      = GUARD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          fft_we,
    output logic          fft_rev,
    output logic [31:0]   fft_addr,
    output logic [DW-1:0] fft_din,
    output logic          fft_sig,
    input  logic [DW-1:0] fft_dout,
    input  logic          fft_busy,
    output logic          frame_busy,
    output logic          done
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW  = $clog2(READ_LAT + 1);
    localparam int unsigned OW  = $clog2(FIFO_DEPTH + READ_LAT + 1);
    localparam int unsigned GW  = $clog2(GUARD + 1);
    localparam logic [LOGN:0] CNT_N    = {1'b1, {LOGN{1'b0}}};
    localparam logic [LOGN:0] CNT_LAST = {1'b0, {LOGN{1'b1}}};
    localparam logic [LOGN:0] CNT_ONE  = {{LOGN{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [LOGN:0]         wcnt_q, wcnt_d;
    logic [LOGN:0]         rcnt_q, rcnt_d;
    logic [LOGN:0]         ocnt_q, ocnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [READ_LAT-1:0]   inflight_q, inflight_d;
    logic [IW-1:0]         inflight_cnt;
    logic [OW-1:0]         occupancy;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  rd_issue, pop;

    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign m_last     = m_valid && (ocnt_q == CNT_LAST);
    assign frame_busy = (state_q != ST_IDLE);

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            inflight_cnt = inflight_cnt + IW'(inflight_q[i]);
        end
        occupancy = OW'(fifo_count) + OW'(inflight_cnt);
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        ocnt_d   = ocnt_q;
        gcnt_d   = gcnt_q;
        s_ready  = 1'b0;
        fft_we   = 1'b0;
        fft_rev  = 1'b0;
        fft_addr = '0;
        fft_din  = '0;
        fft_sig  = 1'b0;
        rd_issue = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                s_ready = !rst;
                if (s_valid && !rst) begin
                    fft_we   = 1'b1;
                    fft_rev  = 1'b1;
                    fft_addr = 32'(wcnt_q[LOGN-1:0]);
                    fft_din  = s_data;
                    if (wcnt_q == CNT_LAST) begin
                        wcnt_d  = '0;
                        state_d = ST_START;
                    end else begin
                        wcnt_d  = wcnt_q + CNT_ONE;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_START: begin
                fft_sig = 1'b1;
                gcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcnt_q != GW'(GUARD)) begin
                    gcnt_d = gcnt_q + GW'(1);
                end else if (!fft_busy) begin
                    rcnt_d  = '0;
                    ocnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Reserve FIFO space for every read still in the RAM pipeline so pushes never overflow.
                rd_issue = (rcnt_q != CNT_N) && !fifo_full && (occupancy < OW'(FIFO_DEPTH));
                fft_addr = (rcnt_q == CNT_N) ? 32'(CNT_LAST[LOGN-1:0]) : 32'(rcnt_q[LOGN-1:0]);
                if (rd_issue) begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
                if (pop) begin
                    ocnt_d = ocnt_q + CNT_ONE;
                end
                if (pop && m_last) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d = (inflight_q << 1) | READ_LAT'(rd_issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            ocnt_q     <= '0;
            gcnt_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            ocnt_q     <= ocnt_d;
            gcnt_q     <= gcnt_d;
            inflight_q <= inflight_d;
        end
    end

    stream_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q[READ_LAT-1]),
        .din   (fft_dout),
        .pop   (pop),
        .dout  (m_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl with a behavioural fft RAM/busy model.
module tb_fft_stream_ctrl;

    localparam int unsigned LOGN     = 12;
    localparam int          N        = 4096;
    localparam int unsigned DW       = 128;
    localparam int          READ_LAT = 2;
    localparam int          GUARD    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          fft_we, fft_rev, fft_sig, fft_busy;
    logic [31:0]   fft_addr;
    logic [DW-1:0] fft_din, fft_dout;
    logic          frame_busy, done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stream_ctrl #(
        .LOGN       (LOGN),
        .DW         (DW),
        .READ_LAT   (READ_LAT),
        .FIFO_DEPTH (4),
        .GUARD      (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .fft_we     (fft_we),
        .fft_rev    (fft_rev),
        .fft_addr   (fft_addr),
        .fft_din    (fft_din),
        .fft_sig    (fft_sig),
        .fft_dout   (fft_dout),
        .fft_busy   (fft_busy),
        .frame_busy (frame_busy),
        .done       (done)
    );

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < int'(LOGN); i++) r[i] = a[int'(LOGN) - 1 - i];
        return r;
    endfunction

    // fft model: bit-reversed write placement, identity transform or address tag readout.
    logic [DW-1:0]   mem [N];
    logic [LOGN-1:0] a1, a2;
    int              bcnt = 0;
    int              busy_len = 0;
    bit              tag_mode = 1'b0;

    always @(posedge clk) begin
        if (fft_we) mem[fft_rev ? bitrev(fft_addr[LOGN-1:0]) : fft_addr[LOGN-1:0]] <= fft_din;
        a1 <= fft_addr[LOGN-1:0];
        a2 <= a1;
        if (rst) bcnt <= 0;
        else if (fft_sig) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    assign fft_busy = (bcnt != 0);
    assign fft_dout = tag_mode ? {64'(a2), ~64'(a2)} : mem[a2];

    function automatic logic [DW-1:0] exp_data(input int k, input bit tm);
        logic [LOGN-1:0] kk;
        kk = k[LOGN-1:0];
        return tm ? {64'(kk), ~64'(kk)} : {64'(bitrev(kk)), 64'd0};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string p, input bit gaps, input bit rnd, input int blen, input bit tmode);
        int sent = 0, extra = 0, wr_cnt = 0, wr_errs = 0, sig_cnt = 0, sig_cyc = 0, last_wr_cyc = 0;
        int out_cnt = 0, out_errs = 0, last_errs = 0, done_cnt = 0, fb_errs = 0, cycles = 0;
        int first_mv = -1, busyfall = -1, first_out_cyc = -1, last_out_cyc = 0;
        bit fin = 1'b0, tgl = 1'b0, prev_busy = 1'b0;
        logic [DW-1:0] first_data = '0;
        busy_len = blen;
        tag_mode = tmode;
        while (!fin && cycles < 40000) begin
            @(posedge clk); #1;
            tgl = !tgl;
            if (sent < N) s_valid = gaps ? tgl : 1'b1;
            else s_valid = !gaps;
            s_data  = (sent < N) ? {64'(sent), 64'd0} : {2{64'hBAD0_BAD0_BAD0_BAD0}};
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cycles++;
            if (frame_busy !== (sent > 0)) fb_errs++;
            if (s_valid && s_ready) begin
                if (sent < N) sent++;
                else extra++;
            end
            if (fft_we) begin
                if (fft_addr !== 32'(wr_cnt) || fft_rev !== 1'b1 || fft_din !== {64'(wr_cnt), 64'd0})
                    wr_errs++;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (fft_sig) begin
                sig_cnt++;
                sig_cyc = cyc;
            end
            if (prev_busy && !fft_busy) busyfall = cyc;
            prev_busy = fft_busy;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) begin
                if (first_out_cyc < 0) begin
                    first_out_cyc = cyc;
                    first_data = m_data;
                end
                last_out_cyc = cyc;
                if (m_data !== exp_data(out_cnt, tmode)) out_errs++;
                if (m_last !== (out_cnt == N - 1)) last_errs++;
                if (done !== (out_cnt == N - 1)) last_errs++;
                if (done) done_cnt++;
                if (out_cnt == N - 1) fin = 1'b1;
                out_cnt++;
            end else if (done) begin
                last_errs++;
            end
        end
        check_eq({p, "_completed"}, 128'(fin), 128'd1);
        check_eq({p, "_wr_count"}, 128'(wr_cnt), 128'(N));
        check_eq({p, "_wr_addr_data_errs"}, 128'(wr_errs), 128'd0);
        check_eq({p, "_sig_count"}, 128'(sig_cnt), 128'd1);
        check_eq({p, "_sig_after_last_wr"}, 128'(sig_cyc - last_wr_cyc), 128'd1);
        check_eq({p, "_no_accept_outside_load"}, 128'(extra), 128'd0);
        check_eq({p, "_out_count"}, 128'(out_cnt), 128'(N));
        check_eq({p, "_out_data_errs"}, 128'(out_errs), 128'd0);
        check_eq({p, "_first_out"}, first_data, exp_data(0, tmode));
        check_eq({p, "_last_done_errs"}, 128'(last_errs), 128'd0);
        check_eq({p, "_done_count"}, 128'(done_cnt), 128'd1);
        check_eq({p, "_frame_busy_errs"}, 128'(fb_errs), 128'd0);
        if (blen > 0)
            check_eq({p, "_lat_after_busy_fall"}, 128'(first_mv - busyfall >= READ_LAT + 1), 128'd1);
        else
            check_eq({p, "_guard_honoured"}, 128'(first_mv - sig_cyc >= GUARD + READ_LAT + 2), 128'd1);
        if (!rnd)
            check_eq({p, "_back_to_back"}, 128'(last_out_cyc - first_out_cyc), 128'(N - 1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check_eq({p, "_idle_frame_busy"}, 128'(frame_busy), 128'd0);
        check_eq({p, "_idle_m_valid"}, 128'(m_valid), 128'd0);
        check_eq({p, "_idle_s_ready"}, 128'(s_ready), 128'd1);
    endtask

    initial begin
        int sent;
        int cycles;
        void'($urandom(32'd1234));
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 128'(s_ready), 128'd0);
        check_eq("rst_m_valid", 128'(m_valid), 128'd0);
        check_eq("rst_m_last", 128'(m_last), 128'd0);
        check_eq("rst_fft_we", 128'(fft_we), 128'd0);
        check_eq("rst_fft_rev", 128'(fft_rev), 128'd0);
        check_eq("rst_fft_sig", 128'(fft_sig), 128'd0);
        check_eq("rst_frame_busy", 128'(frame_busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        check_eq("rst_fft_addr", 128'(fft_addr), 128'd0);
        check_eq("rst_fft_din", fft_din, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_s_ready", 128'(s_ready), 128'd1);

        run_frame("f1", 1'b0, 1'b0, 100, 1'b0);
        run_frame("f2", 1'b1, 1'b1, 0, 1'b1);

        // Abort a frame after 1000 writes, then check a clean restart.
        busy_len = 20;
        tag_mode = 1'b0;
        sent = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 2000) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = {64'(sent), 64'd0};
            m_ready = 1'b1;
            @(negedge clk);
            cycles++;
            if (s_valid && s_ready) sent++;
        end
        check_eq("abort_reached_1000", 128'(sent), 128'd1000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_rst_s_ready", 128'(s_ready), 128'd0);
        check_eq("abort_rst_fft_we", 128'(fft_we), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_after_s_ready", 128'(s_ready), 128'd1);
        check_eq("abort_after_frame_busy", 128'(frame_busy), 128'd0);
        check_eq("abort_after_m_valid", 128'(m_valid), 128'd0);
        check_eq("abort_after_fft_addr", 128'(fft_addr), 128'd0);

        run_frame("f3", 1'b0, 1'b0, 20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fft_stream_ctrl.md
Name: fft_stream_ctrl

Overview:
Upstream/downstream sequencer wrapped around the fft core. It accepts a ready/valid stream of 2^LOGN complex samples and writes them into the fft data RAM with bit-reversed addressing. It then pulses the fft start strobe, waits for the transform to finish, and streams the results back out in natural order on a second ready/valid port. It replaces the hand-driven load/start/unload sequence used in bench bring-up with a synthesizable controller.

Parameters:
LOGN, 12, log2 of transform length N (N = 4096)
DW, 128, complex sample width; real in [127:64], imag in [63:0] (IEEE-754 double each)
READ_LAT, 2, fft dout latency in cycles from fft_addr change
FIFO_DEPTH, 4, output skid FIFO entries; must be >= READ_LAT+1
GUARD, 4, cycles after fft_sig during which fft_busy is ignored

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  DW  input complex sample
m_valid  out  1  output sample valid
m_ready  in  1  output sample ready
m_data  out  DW  output complex sample
m_last  out  1  marks output sample N-1
fft_we  out  1  fft RAM write enable
fft_rev  out  1  fft bit-reverse address select
fft_addr  out  32  fft RAM address (upper 32-LOGN bits zero)
fft_din  out  DW  fft write data
fft_sig  out  1  fft start strobe
fft_dout  in  DW  fft read data
fft_busy  in  1  fft transform in progress
frame_busy  out  1  high from first accepted input until last output handshake
done  out  1  one-cycle pulse on the m_last handshake

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values:
  - state = IDLE.
  - s_ready, m_valid, m_last, fft_we, fft_rev, fft_sig, frame_busy, done all 0.
  - fft_addr = 0, fft_din = 0.
  - FIFO empty; all counters 0.
- FSM states: IDLE, LOAD, START, WAIT, DRAIN.
- IDLE:
  - s_ready = 1.
  - On the first s_valid&s_ready: write sample 0, set frame_busy = 1, go to LOAD.
- LOAD:
  - s_ready = 1.
  - Each handshake drives, in the same cycle: fft_we = 1, fft_rev = 1, fft_addr = wcnt, fft_din = s_data. wcnt then increments.
  - fft_we = 0 in cycles without a handshake.
  - The handshake with wcnt = N-1 goes to START; s_ready drops the next cycle.
  - Maximum rate is one sample per cycle.
- START:
  - fft_sig = 1 for exactly one cycle, fft_we = 0, fft_rev = 0; then go to WAIT.
- WAIT:
  - fft_busy is ignored for GUARD cycles.
  - After the guard, the first cycle with fft_busy = 0 goes to DRAIN with rcnt = 0.
- DRAIN:
  - fft_rev = 0, fft_addr = rcnt.
  - A read is issued (rcnt increments) only when fifo_count + inflight < FIFO_DEPTH.
  - The inflight shift register is READ_LAT deep. At its tail, fft_dout is pushed into the FIFO.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = 1 when the head is sample N-1; done pulses on that handshake.
  - After that handshake: frame_busy = 0, go to IDLE.
  - Output order is natural index 0..N-1, with no gaps or duplicates under any m_ready pattern.
  - With m_ready held at 1, sustained throughput is one sample per cycle.
- Boundary conditions:
  - s_valid while not in IDLE/LOAD: s_ready = 0 and no write occurs.
  - wcnt and rcnt are LOGN+1 bits wide; there is no wrap within a frame.
  - m_ready = 0 with the FIFO full: reads stall, fft_addr holds, and no data is lost.
  - Simultaneous FIFO push and pop: count unchanged.
  - rst mid-frame (any state): next cycle all outputs are at reset values and the FIFO is flushed. The fft core is reset by the same rst.
  - fft_busy never asserting after fft_sig: proceeds to DRAIN once the guard expires (core too fast to observe).
- Arithmetic: no arithmetic on samples; data passes through bit-exact.

Decomposition:
- Shared header/package `top.vh`: LOGN (`logN), DW, the real/imag field macros (`r, `i), and the FSM state encodings.
- One sub-module: stream_fifo (parameterized DW/DEPTH, synchronous FIFO with count, full, empty), used as the output skid buffer.

Test Plan:
- Load N=4096 samples with s_valid always high, real = index, imag = 0 -> exactly 4096 fft_we pulses at addr 0..4095 with fft_rev = 1, then one fft_sig pulse one cycle after the last write.
- Behavioural fft model holding fft_busy high for 100 cycles, m_ready = 1 -> first m_valid no earlier than busy fall + READ_LAT + 1 cycles; 4096 consecutive outputs; m_last and done only on output 4095.
- Random m_ready (50% duty, seed fixed) with model dout = {addr, ~addr} -> output sequence equals addr 0..4095 exactly, with no duplicates or drops.
- Input gaps (s_valid toggling every cycle) -> write count still 4096 and fft_sig fires once; frame_busy stays high until the final handshake.
- rst asserted in LOAD at wcnt = 1000, then a new full frame -> s_ready = 1 the cycle after reset and the new frame's writes restart at addr 0.
- Impulse input (sample 0 = 1.0, all others 0) through the real fft core -> all 4096 outputs have real 3FF0000000000000 and imag 0000000000000000.
